// File: rtl/corelet_ctrl_if.sv
// Control/status bundle between the corelet sequencer and the corelet datapath/SRAMs.
// The master side is the sequencer; the slave side is the corelet, SRAMs and job requester.
interface corelet_ctrl_if #(
  parameter int len_bw  = 6,
  parameter int addr_bw = 11
);
  logic               start;
  logic [len_bw-1:0]  num_act;
  logic [addr_bw-1:0] w_base;
  logic [addr_bw-1:0] a_base;
  logic [addr_bw-1:0] o_base;
  logic               l0_ready;
  logic               ofifo_valid;
  logic [6:0]         inst;
  logic               xmem_en;
  logic [addr_bw-1:0] xmem_addr;
  logic               pmem_wr;
  logic [addr_bw-1:0] pmem_addr;
  logic               busy;
  logic               done;

  modport master (
    input  start, num_act, w_base, a_base, o_base, l0_ready, ofifo_valid,
    output inst, xmem_en, xmem_addr, pmem_wr, pmem_addr, busy, done
  );

  modport slave (
    output start, num_act, w_base, a_base, o_base, l0_ready, ofifo_valid,
    input  inst, xmem_en, xmem_addr, pmem_wr, pmem_addr, busy, done
  );
endinterface

// File: rtl/corelet_ctrl.sv
// Corelet job sequencer: weight load, kernel settle, activation stream, psum drain.
// Generates the 7-bit corelet inst bus plus xmem read / pmem write strobes.
module corelet_ctrl #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int len_bw  = 6,
  parameter int addr_bw = 11
) (
  input  logic            clk,
  input  logic            reset,
  corelet_ctrl_if.master  bus
);

  localparam int SET_W = $clog2(row + col + 1);
  localparam int CNT_W = (len_bw > SET_W) ? len_bw : SET_W;

  typedef enum logic [2:0] {
    IDLE, W_WR, W_RD, W_SET, A_WR, EXEC, DRAIN, DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [len_bw-1:0]  rd_q, rd_d;
  logic [len_bw-1:0]  j_q, j_d;
  logic [len_bw-1:0]  n_q, n_d;
  logic [addr_bw-1:0] w_base_q, w_base_d;
  logic [addr_bw-1:0] a_base_q, a_base_d;
  logic [addr_bw-1:0] o_base_q, o_base_d;
  logic               l0_wr_q, l0_wr_d;
  logic               pmem_wr_q, pmem_wr_d;

  logic               xmem_en;
  logic               ofifo_rd;
  logic               l0_rd;
  logic               execute;
  logic               kernel_load;
  logic [CNT_W-1:0]   n_last;

  assign n_last = CNT_W'(n_q) - CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_q      <= '0;
      j_q       <= '0;
      n_q       <= '0;
      w_base_q  <= '0;
      a_base_q  <= '0;
      o_base_q  <= '0;
      l0_wr_q   <= 1'b0;
      pmem_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      j_q       <= j_d;
      n_q       <= n_d;
      w_base_q  <= w_base_d;
      a_base_q  <= a_base_d;
      o_base_q  <= o_base_d;
      l0_wr_q   <= l0_wr_d;
      pmem_wr_q <= pmem_wr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    j_d      = j_q;
    n_d      = n_q;
    w_base_d = w_base_q;
    a_base_d = a_base_q;
    o_base_d = o_base_q;
    l0_wr_d  = xmem_en;
    pmem_wr_d = ofifo_rd;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          n_d      = bus.num_act;
          w_base_d = bus.w_base;
          a_base_d = bus.a_base;
          o_base_d = bus.o_base;
          cnt_d    = '0;
          rd_d     = '0;
          j_d      = '0;
          state_d  = W_WR;
        end
      end
      W_WR: begin
        if (bus.l0_ready) begin
          if (cnt_q == CNT_W'(col - 1)) begin
            cnt_d   = '0;
            state_d = W_RD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      W_RD: begin
        if (cnt_q == CNT_W'(col - 1)) begin
          cnt_d   = '0;
          state_d = W_SET;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      W_SET: begin
        if (cnt_q == CNT_W'(row + col - 1)) begin
          cnt_d   = '0;
          state_d = (n_q == '0) ? DONE : A_WR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      A_WR: begin
        if (bus.l0_ready) begin
          if (cnt_q == n_last) begin
            cnt_d   = '0;
            state_d = EXEC;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      EXEC: begin
        if (cnt_q == n_last) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        // Reads and writes overlap: rd_q counts OFIFO pops, j_q counts pmem writes one cycle behind.
        if (ofifo_rd) rd_d = rd_q + len_bw'(1);
        if (pmem_wr_q) begin
          j_d = j_q + len_bw'(1);
          if (j_q == n_q - len_bw'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    xmem_en       = 1'b0;
    bus.xmem_addr = '0;
    ofifo_rd      = 1'b0;
    l0_rd         = 1'b0;
    execute       = 1'b0;
    kernel_load   = 1'b0;
    case (state_q)
      W_WR: begin
        xmem_en       = bus.l0_ready;
        bus.xmem_addr = bus.l0_ready ? (w_base_q + addr_bw'(cnt_q)) : '0;
      end
      A_WR: begin
        xmem_en       = bus.l0_ready;
        bus.xmem_addr = bus.l0_ready ? (a_base_q + addr_bw'(cnt_q)) : '0;
      end
      W_RD: begin
        l0_rd       = 1'b1;
        kernel_load = 1'b1;
      end
      EXEC: begin
        l0_rd   = 1'b1;
        execute = 1'b1;
      end
      DRAIN:   ofifo_rd = bus.ofifo_valid && (rd_q < n_q);
      default: ;
    endcase
    bus.xmem_en   = xmem_en;
    bus.inst      = {ofifo_rd, 2'b00, l0_rd, l0_wr_q, execute, kernel_load};
    bus.pmem_wr   = pmem_wr_q;
    bus.pmem_addr = pmem_wr_q ? (o_base_q + addr_bw'(j_q)) : '0;
    bus.busy      = (state_q != IDLE);
    bus.done      = (state_q == DONE);
  end

endmodule

// File: tb/tb_corelet_ctrl.sv
// Directed bench for corelet_ctrl: reset abort, full jobs, l0 stall, N=0, ignored starts, pmem wrap.
module tb_corelet_ctrl;
  localparam int ROW = 8, COL = 8, LEN_BW = 6, ADDR_BW = 11;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  corelet_ctrl_if #(.len_bw(LEN_BW), .addr_bw(ADDR_BW)) bus();
  corelet_ctrl #(.row(ROW), .col(COL), .len_bw(LEN_BW), .addr_bw(ADDR_BW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: written only here, read by the stimulus process as deltas.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [ADDR_BW-1:0] xq[$];
  logic [ADDR_BW-1:0] pq[$];
  int n_kl = 0, n_ex = 0, n_wr = 0, n_or = 0, n_done = 0, n_bad = 0;
  int kl_last = 0, done_last = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.xmem_en) xq.push_back(bus.xmem_addr);
      if (bus.pmem_wr) pq.push_back(bus.pmem_addr);
      if (bus.inst[3] && bus.inst[0]) begin n_kl++; kl_last = cyc; end
      if (bus.inst[3] && bus.inst[1]) n_ex++;
      if (bus.inst[2]) n_wr++;
      if (bus.inst[6]) n_or++;
      if (bus.inst[5:4] != 2'b00) n_bad++;
      if (bus.done) begin n_done++; done_last = cyc; end
    end
  end

  int xb, pb, kl0, ex0, wr0, or0, dn0, bad0;

  task automatic snap();
    xb = xq.size(); pb = pq.size();
    kl0 = n_kl; ex0 = n_ex; wr0 = n_wr; or0 = n_or; dn0 = n_done; bad0 = n_bad;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_job(input int n, input int wb, input int ab, input int ob);
    bus.num_act = LEN_BW'(n);
    bus.w_base  = ADDR_BW'(wb);
    bus.a_base  = ADDR_BW'(ab);
    bus.o_base  = ADDR_BW'(ob);
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit poke);
    int t;
    bit seen;
    t = 0; seen = 1'b0;
    while (t < 400 && !seen) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        if (poke) begin
          bus.start   = 1'b1;
          bus.num_act = 6'd9;
          bus.w_base  = 11'h555;
        end
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      t++;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic check_job(input string tag, input int n, input int wb, input int ab, input int ob);
    check({tag, "_xmem_cnt"}, xq.size() - xb, COL + n);
    for (int k = 0; k < COL && xb + k < xq.size(); k++)
      check({tag, "_w_addr"}, 32'(xq[xb + k]), (wb + k) & 32'h7FF);
    for (int k = 0; k < n && xb + COL + k < xq.size(); k++)
      check({tag, "_a_addr"}, 32'(xq[xb + COL + k]), (ab + k) & 32'h7FF);
    check({tag, "_pmem_cnt"}, pq.size() - pb, n);
    for (int k = 0; k < n && pb + k < pq.size(); k++)
      check({tag, "_p_addr"}, 32'(pq[pb + k]), (ob + k) & 32'h7FF);
    check({tag, "_kload_cyc"}, n_kl - kl0, COL);
    check({tag, "_exec_cyc"}, n_ex - ex0, n);
    check({tag, "_l0_wr"}, n_wr - wr0, COL + n);
    check({tag, "_ofifo_rd"}, n_or - or0, n);
    check({tag, "_done_cnt"}, n_done - dn0, 1);
    check({tag, "_ififo_bits"}, n_bad - bad0, 0);
  endtask

  initial begin
    bit saw;
    reset = 1'b1;
    bus.start = 1'b0; bus.num_act = '0;
    bus.w_base = '0; bus.a_base = '0; bus.o_base = '0;
    bus.l0_ready = 1'b1; bus.ofifo_valid = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("rst_inst", 32'(bus.inst), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_xmem_en", 32'(bus.xmem_en), 32'd0);
    check("rst_pmem_wr", 32'(bus.pmem_wr), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Reset mid-EXEC aborts immediately.
    start_job(4, 'h010, 'h020, 'h100);
    saw = 1'b0;
    for (int t = 0; t < 100 && !saw; t++) begin
      @(negedge clk);
      if (bus.inst[1]) saw = 1'b1;
    end
    check("abort_reach_exec", 32'(saw), 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    #1;
    check("abort_inst", 32'(bus.inst), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_xmem_en", 32'(bus.xmem_en), 32'd0);
    check("abort_pmem_wr", 32'(bus.pmem_wr), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("abort_idle", 32'(bus.busy), 32'd0);
    tick();

    // Full job N=4 after the abort.
    snap();
    start_job(4, 'h010, 'h020, 'h100);
    wait_done("job4", 1'b0);
    check_job("job4", 4, 'h010, 'h020, 'h100);
    check("job4_p0", 32'(pq[pb + 0]), 32'h100);
    check("job4_p3", 32'(pq[pb + 3]), 32'h103);
    @(negedge clk);
    check("job4_idle_busy", 32'(bus.busy), 32'd0);
    check("job4_idle_done", 32'(bus.done), 32'd0);
    tick();

    // l0_ready low for 3 cycles after weight k=3 issued.
    snap();
    start_job(2, 'h040, 'h060, 'h080);
    saw = 1'b0;
    for (int t = 0; t < 50 && !saw; t++) begin
      if (xq.size() - xb >= 4) saw = 1'b1;
      else tick();
    end
    check("stall_reach_k4", 32'(saw), 32'd1);
    bus.l0_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_xmem_en", 32'(bus.xmem_en), 32'd0);
      @(posedge clk); #1;
    end
    bus.l0_ready = 1'b1;
    wait_done("stall", 1'b0);
    check_job("stall", 2, 'h040, 'h060, 'h080);
    tick();

    // N=0: done directly after W_SET's row+col cycles.
    snap();
    start_job(0, 'h055, 'h066, 'h077);
    wait_done("n0", 1'b0);
    check_job("n0", 0, 'h055, 'h066, 'h077);
    check("n0_set_gap", done_last - kl_last, ROW + COL + 1);
    tick();

    // Starts while busy and in DONE are ignored.
    snap();
    start_job(3, 'h200, 'h300, 'h400);
    for (int i = 0; i < 12; i++) tick();
    bus.num_act = 6'd7; bus.w_base = 11'h5AA; bus.a_base = 11'h5BB; bus.o_base = 11'h5CC;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done("ign", 1'b1);
    @(negedge clk);
    check("ign_after_done_busy", 32'(bus.busy), 32'd0);
    check_job("ign", 3, 'h200, 'h300, 'h400);
    tick();

    // pmem and xmem address wrap.
    snap();
    start_job(4, 'h7FC, 'h7FA, 'h7FE);
    wait_done("wrap", 1'b0);
    check_job("wrap", 4, 'h7FC, 'h7FA, 'h7FE);
    check("wrap_p0", 32'(pq[pb + 0]), 32'h7FE);
    check("wrap_p1", 32'(pq[pb + 1]), 32'h7FF);
    check("wrap_p2", 32'(pq[pb + 2]), 32'h000);
    check("wrap_p3", 32'(pq[pb + 3]), 32'h001);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
